// File: rtl/uart_cmd_bridge_pkg.sv
// Shared constants and FSM state type for the UART command bridge.
// Command/response byte values are fixed by the host-side protocol.
package uart_cmd_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [3:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StDoWr,
        StDoRd,
        StRdCap,
        StSend,
        StTxHold,
        StTxWait
    } state_e;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WR) || (b == CMD_RD);
    endfunction

endpackage

// File: rtl/uart_cmd_bridge_if.sv
// Byte streams from/to uart_basic plus the 8-bit register bus, seen from the bridge (master)
// and from the surrounding UART/register logic (slave).
interface uart_cmd_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 4
) ();

    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [7:0]            reg_wdata;
    logic                  reg_we;
    logic                  reg_re;
    logic [7:0]            reg_rdata;

    modport master (
        input  rx_data, rx_ready, tx_busy, reg_rdata,
        output tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output rx_data, rx_ready, tx_busy, reg_rdata,
        input  tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re
    );

endinterface

// File: rtl/uart_cmd_bridge_timeout.sv
// Inter-byte timeout counter: clear wins over enable; saturates once expired is raised.
module uart_cmd_bridge_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntWidth-1:0] Limit = CntWidth'(TIMEOUT_CYCLES);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == Limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART command decoder: 'W' ADDR DATA writes a register and replies 'K'; 'R' ADDR replies with
// the register value; anything malformed replies 'E' and pulses err.
module uart_cmd_bridge
    import uart_cmd_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    uart_cmd_bridge_if.master bus,
    output logic              err
);

    state_e                state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  err_q, err_d;
    logic                  tx_start, reg_we, reg_re;
    logic                  to_clear, to_en, to_expired;

    uart_cmd_bridge_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (to_clear),
        .enable (to_en),
        .expired(to_expired)
    );

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_data_d = tx_data_q;
        err_d     = 1'b0;
        tx_start  = 1'b0;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        to_clear  = 1'b0;
        to_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                to_clear = 1'b1;
                if (bus.rx_ready) begin
                    is_wr_d = (bus.rx_data == CMD_WR);
                    if (is_cmd(bus.rx_data)) begin
                        state_d = StGetAddr;
                    end else begin
                        tx_data_d = RSP_ERR;
                        err_d     = 1'b1;
                        state_d   = StSend;
                    end
                end
            end
            StGetAddr: begin
                to_en = 1'b1;
                // An arriving byte beats a simultaneous expiry.
                if (bus.rx_ready) begin
                    to_clear = 1'b1;
                    if ((bus.rx_data >> ADDR_WIDTH) != 8'h00) begin
                        tx_data_d = RSP_ERR;
                        err_d     = 1'b1;
                        state_d   = StSend;
                    end else begin
                        addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
                        state_d = is_wr_q ? StGetData : StDoRd;
                    end
                end else if (to_expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StGetData: begin
                to_en = 1'b1;
                if (bus.rx_ready) begin
                    to_clear = 1'b1;
                    wdata_d  = bus.rx_data;
                    state_d  = StDoWr;
                end else if (to_expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StDoWr: begin
                reg_we    = 1'b1;
                tx_data_d = RSP_OK;
                state_d   = StSend;
            end
            StDoRd: begin
                reg_re  = 1'b1;
                state_d = StRdCap;
            end
            StRdCap: begin
                tx_data_d = bus.reg_rdata;
                state_d   = StSend;
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = StTxHold;
                end
            end
            // Gives the transmitter a cycle to raise tx_busy before we watch it.
            StTxHold: state_d = StTxWait;
            StTxWait: begin
                if (!bus.tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.rx_ready && !(state_q inside {StIdle, StGetAddr, StGetData})) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            tx_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

    assign bus.tx_start  = tx_start;
    assign bus.tx_data   = tx_data_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_we    = reg_we;
    assign bus.reg_re    = reg_re;
    assign err           = err_q;

endmodule
